spio_uart_byte_tx: RTL and testbench
====================================

// Module: spio_uart_byte_tx
// PURPOSE
//  Byte-to-serial UART transmitter. Sits directly downstream of the transmit
//  control stage and consumes its 8-bit valid/ready byte stream.
//  Each accepted byte goes out as one frame: 1 start bit (0), 8 data bits LSB
//  first, 1 stop bit (1).
//  Hardware flow control: new frames start only while the far end asserts CTS.
// PARAMETERS
//  DIV_BITS  16  width of BIT_PERIOD_IN; the bit-period counter is this wide
// PORTS
//  CLK_IN         in   1         clock
//  RESET_IN       in   1         reset, asynchronous, active-high
//  BIT_PERIOD_IN  in   DIV_BITS  clock cycles per bit, minus 1 (0 => 1 cycle/bit)
//  CTS_IN         in   1         far-end clear-to-send, asynchronous, active-high
//  BYTE_DATA_IN   in   8         byte to transmit
//  BYTE_VLD_IN    in   1         BYTE_DATA_IN is valid
//  BYTE_RDY_OUT   out  1         block will accept a byte this cycle
//  TX_OUT         out  1         serial line; idle high; registered
//  BUSY_OUT       out  1         high while a frame is in progress (START/DATA/STOP)
// BEHAVIOUR
//  Reset (async): state=RESET, TX_OUT=1, BYTE_RDY_OUT=0, BUSY_OUT=0,
//   cts_sync=0. Any frame in progress is abandoned; the line returns to idle-high
//   at once.
//  CTS_IN passes through a 2-flop synchroniser (reset 0) -> cts_sync.
//   A CTS_IN edge is visible on cts_sync 2 cycles later.
//  States:
//   RESET -> IDLE unconditionally after 1 cycle.
//   IDLE: on handshake, latch data and period, bit_timer:=period, go to START.
//   START: TX_OUT=0; go to DATA when bit_timer==0, with bit_idx:=0.
//   DATA: TX_OUT=shift[0]. When bit_timer==0, shift right and bit_idx++.
//     Go to STOP after bit_idx==7 expires.
//   STOP: TX_OUT=1. When bit_timer==0: go to START if a handshake occurs this
//     cycle, else go to IDLE.
//  Bit timer:
//   - Reloads with the latched period on every bit boundary.
//   - Otherwise decrements by 1.
//   - Each bit lasts exactly period+1 cycles.
//  Handshake: a byte is accepted when BYTE_VLD_IN && BYTE_RDY_OUT.
//   BYTE_RDY_OUT is combinational:
//     BYTE_RDY_OUT = cts_sync && (state==IDLE || (state==STOP && bit_timer==0)).
//   BYTE_RDY_OUT does not depend on BYTE_VLD_IN.
//  Latency: TX_OUT falls to 0 on the first clock edge after the handshake.
//   Back-to-back frames have no idle gap.
//   Frame period is 10*(period+1) cycles.
//  BIT_PERIOD_IN is sampled only at the handshake; changes mid-frame take
//   effect from the next frame.
//  CTS deasserted mid-frame: the current frame always completes.
//   No new handshake occurs until cts_sync is high again.
//  BYTE_DATA_IN is ignored when there is no handshake.
//   The latched byte is never altered mid-frame.
//  BUSY_OUT = (state is START, DATA or STOP); it is registered via the state.
//  Illegal state encodings fall to RESET; TX_OUT is 1 in every state other than
//   START and DATA.
// TESTING
//  1. P=3, CTS=1, send 0xA5 -> TX_OUT bits 0,1,0,1,0,0,1,0,1,1.
//     Each bit holds 4 cycles; the first 0 appears the cycle after the
//     handshake; RDY is high on the last stop cycle.
//  2. P=0, VLD held with 0x00 then 0xFF -> 20 contiguous bit cycles:
//     0,00000000,1,0,11111111,1. No idle cycle between frames.
//  3. CTS 1->0 during DATA of 0x3C -> the frame completes intact.
//     RDY stays 0 with VLD=1 until 2 cycles after CTS returns to 1.
//  4. Send with P=1, then change BIT_PERIOD_IN to 7 mid-frame.
//     -> The frame keeps 2-cycle bits; the next frame uses 8-cycle bits.
//  5. Assert RESET_IN mid-DATA -> TX_OUT=1 and RDY=0 immediately.
//     After release: 1 RESET cycle, then RDY=1 once cts_sync=1.
//  6. Chain with the transmit control stage and pulse a sync trigger.
//     -> 13 frames of 0x00 then 1 frame of 0xFF, back-to-back, decode correctly.

Source files
------------

// File: rtl/spio_uart_byte_tx.sv
// Byte-to-serial UART transmitter: 8N1 framing, valid/ready byte input,
// CTS-gated frame start, programmable bit period.
module spio_uart_byte_tx #(
    parameter int unsigned DIV_BITS = 16
) (
    input  logic                CLK_IN,
    input  logic                RESET_IN,
    input  logic [DIV_BITS-1:0] BIT_PERIOD_IN,
    input  logic                CTS_IN,
    input  logic [7:0]          BYTE_DATA_IN,
    input  logic                BYTE_VLD_IN,
    output logic                BYTE_RDY_OUT,
    output logic                TX_OUT,
    output logic                BUSY_OUT
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                cts_meta;
    logic                cts_sync;
    logic [DIV_BITS-1:0] period_q;
    logic [DIV_BITS-1:0] bit_timer;
    logic [BYTE_W-1:0]   shift_q;
    logic [BYTE_W-1:0]   shift_nx;
    logic [IDX_W-1:0]    bit_idx;
    logic                timer_zero;
    logic                handshake;
    logic                in_frame;
    logic                tx_nx;
    logic                busy_nx;

    // CTS crosses in from the far end: two-flop synchroniser
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            cts_meta <= 1'b0;
            cts_sync <= 1'b0;
        end else begin
            cts_meta <= CTS_IN;
            cts_sync <= cts_meta;
        end
    end

    assign timer_zero   = (bit_timer == '0);
    assign in_frame     = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    assign BYTE_RDY_OUT = cts_sync && ((state == ST_IDLE) || ((state == ST_STOP) && timer_zero));
    assign handshake    = BYTE_VLD_IN && BYTE_RDY_OUT;

    // State register
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state <= ST_RESET;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; the STOP->START path gives back-to-back frames
    always_comb begin
        state_nx = state;
        case (state)
            ST_RESET: state_nx = ST_IDLE;
            ST_IDLE:  if (handshake) state_nx = ST_START;
            ST_START: if (timer_zero) state_nx = ST_DATA;
            ST_DATA:  if (timer_zero && (bit_idx == IDX_W'(BYTE_W - 1))) state_nx = ST_STOP;
            ST_STOP:  if (timer_zero) state_nx = handshake ? ST_START : ST_IDLE;
            default:  state_nx = ST_RESET;
        endcase
    end

    // Shift register content for the next cycle
    always_comb begin
        shift_nx = shift_q;
        if (handshake) begin
            shift_nx = BYTE_DATA_IN;
        end else if ((state == ST_DATA) && timer_zero) begin
            shift_nx = shift_q >> 1;
        end
    end

    // Output decode from the upcoming state, so TX_OUT/BUSY_OUT can be flopped
    always_comb begin
        tx_nx   = 1'b1;
        busy_nx = 1'b0;
        case (state_nx)
            ST_START: begin
                tx_nx   = 1'b0;
                busy_nx = 1'b1;
            end
            ST_DATA: begin
                tx_nx   = shift_nx[0];
                busy_nx = 1'b1;
            end
            ST_STOP: begin
                tx_nx   = 1'b1;
                busy_nx = 1'b1;
            end
            default: begin
                tx_nx   = 1'b1;
                busy_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            TX_OUT   <= 1'b1;
            BUSY_OUT <= 1'b0;
        end else begin
            TX_OUT   <= tx_nx;
            BUSY_OUT <= busy_nx;
        end
    end

    // Bit timing and data path; period is captured only at the handshake
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            shift_q   <= '0;
            period_q  <= '0;
            bit_timer <= '0;
            bit_idx   <= '0;
        end else begin
            shift_q <= shift_nx;
            if (handshake) begin
                period_q  <= BIT_PERIOD_IN;
                bit_timer <= BIT_PERIOD_IN;
            end else if (in_frame) begin
                if (timer_zero) begin
                    bit_timer <= period_q;
                end else begin
                    bit_timer <= bit_timer - DIV_BITS'(1);
                end
            end
            if ((state == ST_START) && timer_zero) begin
                bit_idx <= '0;
            end else if ((state == ST_DATA) && timer_zero) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spio_uart_byte_tx.sv
// Self-checking bench for spio_uart_byte_tx: a per-cycle line model plus
// directed frame captures checked against hand-written bit patterns.
module tb_spio_uart_byte_tx;

    localparam int unsigned DIV_BITS = 16;

    logic                CLK_IN = 1'b0;
    logic                RESET_IN;
    logic [DIV_BITS-1:0] BIT_PERIOD_IN;
    logic                CTS_IN;
    logic [7:0]          BYTE_DATA_IN;
    logic                BYTE_VLD_IN;
    logic                BYTE_RDY_OUT;
    logic                TX_OUT;
    logic                BUSY_OUT;

    int n_pass  = 0;
    int n_total = 0;

    spio_uart_byte_tx #(.DIV_BITS(DIV_BITS)) dut (
        .CLK_IN        (CLK_IN),
        .RESET_IN      (RESET_IN),
        .BIT_PERIOD_IN (BIT_PERIOD_IN),
        .CTS_IN        (CTS_IN),
        .BYTE_DATA_IN  (BYTE_DATA_IN),
        .BYTE_VLD_IN   (BYTE_VLD_IN),
        .BYTE_RDY_OUT  (BYTE_RDY_OUT),
        .TX_OUT        (TX_OUT),
        .BUSY_OUT      (BUSY_OUT)
    );

    initial forever #5 CLK_IN = ~CLK_IN;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Line model: one queued line value per future cycle of the current frame
    bit m_q[$];
    bit m_meta   = 1'b0;
    bit m_sync   = 1'b0;
    bit m_in_rst = 1'b1;
    bit m_hs;

    function bit m_rdy();
        return m_sync && !m_in_rst && (m_q.size() <= 1);
    endfunction

    function void m_push_frame(input logic [7:0] d, input int p);
        bit v;
        for (int b = 0; b < 10; b++) begin
            if (b == 0) v = 1'b0;
            else if (b == 9) v = 1'b1;
            else v = d[b-1];
            for (int r = 0; r <= p; r++) m_q.push_back(v);
        end
    endfunction

    always @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            m_q.delete();
            m_meta   = 1'b0;
            m_sync   = 1'b0;
            m_in_rst = 1'b1;
        end else begin
            m_hs = BYTE_VLD_IN && m_rdy();
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (m_hs) m_push_frame(BYTE_DATA_IN, int'(BIT_PERIOD_IN));
            m_in_rst = 1'b0;
            m_sync   = m_meta;
            m_meta   = CTS_IN;
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge CLK_IN);
        check("tx_line", int'(TX_OUT), (m_q.size() > 0) ? int'(m_q[0]) : 1);
        check("busy",    int'(BUSY_OUT), (m_q.size() > 0) ? 1 : 0);
        check("rdy",     int'(BYTE_RDY_OUT), int'(m_rdy()));
    end

    // Valid/ready byte source; data is junk whenever valid is low
    logic [7:0] src[$];
    initial begin
        BYTE_VLD_IN  = 1'b0;
        BYTE_DATA_IN = 8'h00;
        forever begin
            @(negedge CLK_IN);
            if (BYTE_VLD_IN && BYTE_RDY_OUT && !RESET_IN) void'(src.pop_front());
            BYTE_VLD_IN  = (src.size() > 0);
            BYTE_DATA_IN = (src.size() > 0) ? src[0] : 8'($urandom);
        end
    end

    // Line recorder
    bit rec[$];
    bit rec_en = 1'b0;
    initial forever begin
        @(negedge CLK_IN);
        if (rec_en) rec.push_back(TX_OUT);
    end

    bit exp_bits[$];
    int exp_len[$];

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK_IN);
        #1;
    endtask

    task automatic add_bits(input logic [9:0] b, input int len);
        for (int i = 0; i < 10; i++) begin
            exp_bits.push_back(b[i]);
            exp_len.push_back(len);
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((src.size() > 0 || BYTE_VLD_IN || BUSY_OUT) && k < 3000) begin
            @(negedge CLK_IN);
            k++;
        end
        check({name, "_done_in_time"}, int'(k < 3000), 1);
        cycles(3);
    endtask

    // Compare the recording, from its first low sample, against the expected bit list
    task automatic check_rec(input string name);
        int s = -1;
        int idx;
        int act;
        for (int i = 0; i < rec.size(); i++) begin
            if (rec[i] == 1'b0) begin
                s = i;
                break;
            end
        end
        check({name, "_start_found"}, int'(s >= 0), 1);
        if (s >= 0) begin
            idx = s;
            for (int i = 0; i < exp_bits.size(); i++) begin
                act = int'(exp_bits[i]);
                for (int j = 0; j < exp_len[i]; j++) begin
                    if (idx >= rec.size()) act = 2;
                    else if (rec[idx] != exp_bits[i]) act = int'(rec[idx]);
                    idx++;
                end
                check($sformatf("%s_bit%0d", name, i), act, int'(exp_bits[i]));
            end
        end
        exp_bits.delete();
        exp_len.delete();
        rec.delete();
    endtask

    initial begin
        RESET_IN      = 1'b1;
        CTS_IN        = 1'b0;
        BIT_PERIOD_IN = 16'd3;
        cycles(3);
        check("reset_tx", int'(TX_OUT), 1);
        check("reset_rdy", int'(BYTE_RDY_OUT), 0);
        check("reset_busy", int'(BUSY_OUT), 0);
        RESET_IN = 1'b0;
        CTS_IN   = 1'b1;
        cycles(4);
        check("rdy_after_sync", int'(BYTE_RDY_OUT), 1);

        // 1: single 0xA5 frame, 4-cycle bits
        BIT_PERIOD_IN = 16'd3;
        rec.delete();
        rec_en = 1'b1;
        src.push_back(8'hA5);
        wait_idle("t1");
        rec_en = 1'b0;
        add_bits(10'b1101001010, 4);
        check_rec("t1");

        // 2: back-to-back 0x00, 0xFF at one cycle per bit
        BIT_PERIOD_IN = 16'd0;
        rec_en = 1'b1;
        src.push_back(8'h00);
        src.push_back(8'hFF);
        wait_idle("t2");
        rec_en = 1'b0;
        add_bits(10'b1000000000, 1);
        add_bits(10'b1111111110, 1);
        check_rec("t2");

        // 3: CTS drops mid-frame; next byte held off until CTS resyncs
        BIT_PERIOD_IN = 16'd1;
        rec_en = 1'b1;
        src.push_back(8'h3C);
        cycles(8);
        CTS_IN = 1'b0;
        src.push_back(8'h81);
        cycles(30);
        check("t3_vld_waiting", int'(BYTE_VLD_IN), 1);
        check("t3_rdy_held", int'(BYTE_RDY_OUT), 0);
        CTS_IN = 1'b1;
        @(negedge CLK_IN);
        check("t3_rdy_lag0", int'(BYTE_RDY_OUT), 0);
        @(negedge CLK_IN);
        check("t3_rdy_lag1", int'(BYTE_RDY_OUT), 0);
        @(negedge CLK_IN);
        check("t3_rdy_lag2", int'(BYTE_RDY_OUT), 1);
        wait_idle("t3");
        rec_en = 1'b0;
        add_bits(10'b1001111000, 2);
        check_rec("t3");

        // 4: period change mid-frame applies to the following frame only
        BIT_PERIOD_IN = 16'd1;
        rec_en = 1'b1;
        src.push_back(8'h0F);
        src.push_back(8'h33);
        cycles(5);
        BIT_PERIOD_IN = 16'd7;
        wait_idle("t4");
        rec_en = 1'b0;
        add_bits(10'b1000011110, 2);
        add_bits(10'b1001100110, 8);
        check_rec("t4");

        // 5: reset in the middle of the data bits
        BIT_PERIOD_IN = 16'd3;
        src.push_back(8'h00);
        cycles(12);
        check("t5_pre_tx", int'(TX_OUT), 0);
        check("t5_pre_busy", int'(BUSY_OUT), 1);
        RESET_IN = 1'b1;
        #1;
        check("t5_rst_tx", int'(TX_OUT), 1);
        check("t5_rst_rdy", int'(BYTE_RDY_OUT), 0);
        check("t5_rst_busy", int'(BUSY_OUT), 0);
        cycles(2);
        RESET_IN = 1'b0;
        @(negedge CLK_IN);
        check("t5_rdy_rel0", int'(BYTE_RDY_OUT), 0);
        @(negedge CLK_IN);
        check("t5_rdy_rel1", int'(BYTE_RDY_OUT), 0);
        @(negedge CLK_IN);
        check("t5_rdy_rel2", int'(BYTE_RDY_OUT), 1);
        cycles(2);

        // 6: burst of 13 zero bytes then 0xFF, no gaps
        BIT_PERIOD_IN = 16'd0;
        rec_en = 1'b1;
        for (int i = 0; i < 13; i++) src.push_back(8'h00);
        src.push_back(8'hFF);
        wait_idle("t6");
        rec_en = 1'b0;
        for (int i = 0; i < 13; i++) add_bits(10'b1000000000, 1);
        add_bits(10'b1111111110, 1);
        check_rec("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
